// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: streams two WIDTH-bit operands LSB-first through an
// external shared 1-bit full adder and registers the sum, carry-out and signed overflow.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             add_a,
  output logic             add_b,
  output logic             add_cin,
  input  logic             add_s,
  input  logic             add_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  // Counter must be able to represent WIDTH itself.
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign res_next = {add_s, res[WIDTH-1:1]};

  // Full-adder operands are only presented while bits are in flight.
  assign add_a   = (state == RUN) ? a_sh[0] : 1'b0;
  assign add_b   = (state == RUN) ? b_sh[0] : 1'b0;
  assign add_cin = (state == RUN) ? carry   : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      res      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Abort wins over completion, including on the final bit.
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
            res   <= res_next;
            carry <= add_cout;
            cnt   <= cnt + CW'(1);
            if (last_bit) begin
              sum      <= res_next;
              cout     <= add_cout;
              overflow <= add_cin ^ add_cout;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new addition; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  cancel an addition in progress.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port cin  input  1  carry-in for bit 0.
REQ-009 SHALL have port add_a  output  1  bit to the shared 1-bit full adder, A input.
REQ-010 SHALL have port add_b  output  1  bit to the shared 1-bit full adder, B input.
REQ-011 SHALL have port add_cin  output  1  carry to the shared 1-bit full adder.
REQ-012 SHALL have port add_s  input  1  sum bit from the full adder.
REQ-013 SHALL have port add_cout  input  1  carry-out from the full adder.
REQ-014 SHALL have port busy  output  1  high while bits are being processed.
REQ-015 SHALL have port done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port sum  output  WIDTH  registered result.
REQ-017 SHALL have port cout  output  1  registered unsigned carry-out.
REQ-018 SHALL have port overflow  output  1  registered two's-complement overflow flag.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DONE; transitions: IDLE->RUN on start=1; RUN->DONE after WIDTH bit cycles; RUN->IDLE on abort=1; DONE->IDLE unconditionally.
REQ-020 SHALL, at the edge accepting start in IDLE, capture a, b and cin into internal shift/carry registers and clear the bit counter.
REQ-021 SHALL, in RUN, drive add_a = A-shift[0], add_b = B-shift[0] and add_cin = carry register, combinationally.
REQ-022 SHALL drive add_a, add_b and add_cin to 0 in IDLE and DONE.
REQ-023 SHALL, at each RUN edge, shift A and B right by one, shift add_s into the MSB of an internal result register, load add_cout into the carry register, and increment the counter.
REQ-024 SHALL process bits LSB-first; bit i is presented in the (i+1)-th RUN cycle.
REQ-025 SHALL, at the edge processing bit WIDTH-1, load sum from the completed internal result register, cout = add_cout, overflow = add_cin XOR add_cout, and enter DONE.
REQ-026 SHALL hold sum, cout and overflow unchanged at all times other than REQ-025 and reset; an abort or a new operation SHALL NOT disturb them.
REQ-027 SHALL assert busy exactly in RUN and done exactly in DONE; for start accepted at edge n: busy=1 for cycles n+1..n+WIDTH, done=1 for cycle n+WIDTH+1, results valid from cycle n+WIDTH+1.
REQ-028 SHALL ignore start in RUN and DONE; an ignored start SHALL NOT be queued.
REQ-029 SHALL, on abort=1 in RUN, including the final bit cycle, return to IDLE without pulsing done; abort SHALL be ignored in IDLE and DONE.
REQ-030 SHALL give abort priority over completion when both occur in the same cycle.
REQ-031 SHALL size the bit counter to hold WIDTH without wrap-around.

Reset
REQ-032 SHALL, on any rising edge with rst=0, force state IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, and clear the shift registers, carry register and counter, regardless of state, start or abort.
REQ-033 SHALL accept start on the first edge with rst=1.

Verification
REQ-034 SHALL verify, with WIDTH=8: a=8'h0F, b=8'h01, cin=0, start 1 cycle -> busy high 8 cycles, done in cycle 9, sum=8'h10, cout=0, overflow=0.
REQ-035 SHALL verify: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, overflow=0; and a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1, overflow=0.
REQ-036 SHALL verify: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, overflow=1.
REQ-037 SHALL verify that start is ignored during busy: start pulsed in RUN with different operands -> exactly one done, carrying the first result, and sum holding the previous result until then.
REQ-038 SHALL verify: abort in RUN cycle 4 -> IDLE next cycle, no done, sum/cout/overflow unchanged; and rst=0 in RUN cycle 5 -> all outputs 0 next cycle, with a new start accepted after release.
REQ-039 SHALL verify add_a/add_b/add_cin bit order against a bit-accurate reference full adder and check that they are 0 outside RUN.
